axis_write_data: RTL and testbench

- Data half of the stream-to-memory write path; the mirror of the read-side data unpacker.
- Accepts a configured number of narrow system-stream words, packs them into AXI_DATA_WIDTH words, buffers them, and drives the AXI W channel with per-burst WLAST.
- Counts B responses and reports completion to the write controller.
- Sits beside axis_addr, which issues the matching AW bursts from the same cfg_length.

---
 rtl/axis_write_data_pkg.sv | 37 +++
 rtl/axis_write_data_if.sv | 38 +++
 rtl/axis_write_fifo.sv | 60 ++++++
 rtl/axis_write_data.sv | 158 +++++++++++++++
 tb/tb_axis_write_data.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_write_data_pkg.sv
// Shared types and helpers for the stream-to-AXI write data path.
// Holds FSM states, the OKAY response code and burst ceil-division helpers.
package axis_write_data_pkg;

  localparam int DEF_BURST_BEATS = 16;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RESP
  } state_t;

  function automatic logic [63:0] ceil_div(
    input logic [63:0] n,
    input int unsigned d
  );
    logic [64:0] t;
    t = {1'b0, n} + 65'(d) - 65'd1;
    return 64'(t / 65'(d));
  endfunction

  function automatic logic [63:0] calc_beats(
    input logic [63:0] len,
    input int unsigned ratio
  );
    return ceil_div(len, ratio);
  endfunction

  function automatic logic [63:0] calc_bursts(
    input logic [63:0] beats,
    input int unsigned bb
  );
    return ceil_div(beats, bb);
  endfunction

endpackage

// File: rtl/axis_write_data_if.sv
// Bundle of config, stream, AXI W/B and status signals of axis_write_data.
// slave = the data unit's view, master = the surrounding controller's view.
interface axis_write_data_if #(
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
);
  logic [CONFIG_DWIDTH-1:0]    cfg_length;
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic [DATA_WIDTH-1:0]       data;
  logic                        valid;
  logic                        ready;
  logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic                        axi_wlast;
  logic                        axi_wvalid;
  logic                        axi_wready;
  logic [1:0]                  axi_bresp;
  logic                        axi_bvalid;
  logic                        axi_bready;
  logic                        done;
  logic                        error;

  modport slave (
    input  cfg_length, cfg_valid, data, valid,
    input  axi_wready, axi_bresp, axi_bvalid,
    output cfg_ready, ready, axi_wdata, axi_wstrb,
    output axi_wlast, axi_wvalid, axi_bready, done, error
  );

  modport master (
    output cfg_length, cfg_valid, data, valid,
    output axi_wready, axi_bresp, axi_bvalid,
    input  cfg_ready, ready, axi_wdata, axi_wstrb,
    input  axi_wlast, axi_wvalid, axi_bready, done, error
  );
endinterface

// File: rtl/axis_write_fifo.sv
// Synchronous FIFO with a registered head word; writes into an empty FIFO bypass to the head.
// Ports: i_wr/i_wdata push, i_rd pops the head, o_full/o_empty flags, o_rdata head data.
module axis_write_fifo #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_rd,
  output logic              o_full,
  output logic              o_empty,
  output logic [DWIDTH-1:0] o_rdata
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wptr, r_rptr;
  logic [AWIDTH:0]   r_cnt;
  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic w_load, w_mem_empty, w_pop, w_bypass, w_push;

  assign w_mem_empty = (r_cnt == '0);
  assign w_load      = ~r_valid | i_rd;
  assign w_pop       = w_load & ~w_mem_empty;
  assign w_bypass    = w_load & w_mem_empty & i_wr;
  // A pop in the same cycle frees a slot, so full never blocks it
  assign o_full  = (r_cnt == (AWIDTH+1)'(DEPTH)) & ~w_pop;
  assign w_push  = i_wr & ~w_bypass & ~o_full;
  assign o_empty = ~r_valid;
  assign o_rdata = r_data;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AWIDTH'(1);
      if (w_pop)  r_rptr <= r_rptr + AWIDTH'(1);
      if (w_push & ~w_pop)
        r_cnt <= r_cnt + (AWIDTH+1)'(1);
      else if (w_pop & ~w_push)
        r_cnt <= r_cnt - (AWIDTH+1)'(1);
      if (w_load) begin
        r_valid <= w_pop | w_bypass;
        if (w_pop)         r_data <= r_mem[r_rptr];
        else if (w_bypass) r_data <= i_wdata;
      end
    end
  end
endmodule

// File: rtl/axis_write_data.sv
// Packs stream words into AXI words, drives the W channel in bursts and counts B responses.
// Ports: clk, rst (async active-low), bus (cfg, stream, AXI W/B, done, error).
module axis_write_data
  import axis_write_data_pkg::*;
#(
  parameter int BUF_AWIDTH     = 9,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 1,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_BEATS    = DEF_BURST_BEATS
) (
  input logic              clk,
  input logic              rst,
  axis_write_data_if.slave bus
);
  localparam int SW  = AXI_DATA_WIDTH / 8;
  localparam int LSW = DATA_WIDTH / 8;
  localparam int LW  = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;
  localparam int FW  = AXI_DATA_WIDTH + SW;
  localparam logic [AXI_LEN_WIDTH-1:0] LAST_BEAT =
    AXI_LEN_WIDTH'(BURST_BEATS - 1);
  localparam logic [CONFIG_DWIDTH-1:0] ONE = CONFIG_DWIDTH'(1);

  state_t r_state, w_next;
  logic [CONFIG_DWIDTH-1:0]  r_len, r_words, r_wleft, r_bout;
  logic [AXI_LEN_WIDTH-1:0]  r_bbeat;
  logic [AXI_DATA_WIDTH-1:0] r_pack, w_word;
  logic [SW-1:0]             w_strb;
  logic [LW-1:0]             w_lane;
  logic [63:0]               w_beats;
  logic r_done, r_error;
  logic w_cfg_hs, w_s_hs, w_w_hs, w_b_hs, w_b_cnt;
  logic w_last_word, w_fifo_wr, w_wlast;
  logic w_cfg_ready, w_bready, w_done_set;
  logic w_full, w_empty;
  logic [FW-1:0] w_fdata;

  assign w_cfg_hs = bus.cfg_valid & w_cfg_ready;
  assign w_s_hs   = bus.valid & bus.ready;
  assign w_w_hs   = ~w_empty & bus.axi_wready;
  assign w_b_hs   = bus.axi_bvalid & w_bready;
  // Responses beyond the issued burst count are dropped
  assign w_b_cnt  = w_b_hs & (r_bout != '0);

  assign w_lane = (WIDTH_RATIO > 1) ? r_words[LW-1:0] : '0;
  assign w_last_word = (r_words == r_len - ONE);
  assign w_fifo_wr = w_s_hs &
    ((w_lane == LW'(WIDTH_RATIO - 1)) | w_last_word);
  assign w_wlast = ~w_empty &
    ((r_bbeat == LAST_BEAT) | (r_wleft == ONE));
  assign w_beats = calc_beats(64'(bus.cfg_length), WIDTH_RATIO);

  // Current word with the incoming lane merged; strobe covers lanes 0..lane
  always_comb begin
    w_word = r_pack;
    w_word[w_lane*DATA_WIDTH +: DATA_WIDTH] = bus.data;
    w_strb = '0;
    for (int l = 0; l < WIDTH_RATIO; l++)
      if (l <= int'(w_lane)) w_strb[l*LSW +: LSW] = '1;
  end

  always_comb begin
    w_next      = r_state;
    w_cfg_ready = 1'b0;
    w_bready    = 1'b0;
    w_done_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cfg_ready = 1'b1;
        if (w_cfg_hs) begin
          if (bus.cfg_length == '0) w_done_set = 1'b1;
          else                      w_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        w_bready = 1'b1;
        if (w_w_hs & (r_wleft == ONE)) w_next = S_RESP;
      end
      S_RESP: begin
        w_bready = 1'b1;
        if ((r_bout == '0) | (w_b_cnt & (r_bout == ONE))) begin
          w_done_set = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len   <= '0;
      r_words <= '0;
      r_wleft <= '0;
      r_bout  <= '0;
      r_bbeat <= '0;
      r_pack  <= '0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_cfg_hs) begin
        r_len   <= bus.cfg_length;
        r_words <= '0;
        r_wleft <= CONFIG_DWIDTH'(w_beats);
        r_bout  <= CONFIG_DWIDTH'(calc_bursts(w_beats, BURST_BEATS));
        r_bbeat <= '0;
        r_pack  <= '0;
        r_error <= 1'b0;
      end else begin
        if (w_s_hs) begin
          r_words <= r_words + ONE;
          r_pack  <= w_fifo_wr ? '0 : w_word;
        end
        if (w_w_hs) begin
          r_wleft <= r_wleft - ONE;
          r_bbeat <= w_wlast ? '0 : r_bbeat + AXI_LEN_WIDTH'(1);
        end
        if (w_b_cnt) begin
          r_bout <= r_bout - ONE;
          if (bus.axi_bresp != RESP_OKAY) r_error <= 1'b1;
        end
      end
      r_done <= w_done_set;
    end
  end

  axis_write_fifo #(
    .AWIDTH (BUF_AWIDTH),
    .DWIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_fifo_wr),
    .i_wdata ({w_strb, w_word}),
    .i_rd    (w_w_hs),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_rdata (w_fdata)
  );

  assign bus.cfg_ready  = w_cfg_ready;
  assign bus.ready      = (r_state == S_ACTIVE) &
                          (r_words < r_len) & ~w_full;
  assign bus.axi_wvalid = ~w_empty;
  assign bus.axi_wdata  = w_fdata[AXI_DATA_WIDTH-1:0];
  assign bus.axi_wstrb  = w_fdata[FW-1 -: SW];
  assign bus.axi_wlast  = w_wlast;
  assign bus.axi_bready = w_bready;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
endmodule

// File: tb/tb_axis_write_data.sv
// Scoreboard bench for axis_write_data: 8-bit stream packed 4:1 into 32-bit AXI words.
// Small FIFO so backpressure reaches the stream side quickly.
module tb_axis_write_data;
  localparam int RATIO = 4;
  localparam int BB    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_write_data_if #(
    .CONFIG_DWIDTH(32), .AXI_DATA_WIDTH(32), .DATA_WIDTH(8)
  ) bus ();

  axis_write_data #(
    .BUF_AWIDTH(2), .CONFIG_DWIDTH(32), .WIDTH_RATIO(RATIO),
    .AXI_LEN_WIDTH(8), .AXI_DATA_WIDTH(32), .DATA_WIDTH(8),
    .BURST_BEATS(BB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] words[$];
  int vectors = 0;
  int miscompares = 0;
  int wlast_cnt = 0, b_sent = 0, done_cnt = 0, beat_cnt = 0;
  int sent_idx = 0, err_burst = -1, exp_bursts = 0, exp_total = 0;
  bit exp_err = 0, hold = 0, abort = 0, sender_busy = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.axi_wvalid && bus.axi_wready) begin
        if (exp_q.size() == 0) begin
          chk("beat_count", 64'(beat_cnt + 1), 64'(exp_total));
        end else begin
          e = exp_q.pop_front();
          chk("wdata", 64'(bus.axi_wdata), 64'(e.d));
          chk("wstrb", 64'(bus.axi_wstrb), 64'(e.s));
          chk("wlast", 64'(bus.axi_wlast), 64'(e.l));
        end
        beat_cnt++;
        if (bus.axi_wlast) wlast_cnt++;
      end
      if (rst && bus.done) begin
        done_cnt++;
        chk("done_after_last_b", 64'(b_sent), 64'(exp_bursts));
      end
    end
  endtask

  task automatic bresp_proc();
    bit hs = 0;
    forever begin
      @(posedge clk); #1;
      if (hs || !rst) bus.axi_bvalid = 1'b0;
      if (rst && !bus.axi_bvalid && wlast_cnt > b_sent &&
          ($urandom % 3) != 0) begin
        bus.axi_bvalid = 1'b1;
        bus.axi_bresp  = (b_sent == err_burst) ? 2'b10 : 2'b00;
      end
      @(negedge clk);
      hs = rst && bus.axi_bvalid && bus.axi_bready;
      if (hs) b_sent++;
    end
  endtask

  task automatic wready_proc();
    forever begin
      @(posedge clk); #1;
      bus.axi_wready = hold ? 1'b0 : (($urandom % 4) != 0);
    end
  endtask

  task automatic sender();
    bit hs;
    int n = 0;
    sent_idx = 0;
    while (sent_idx < words.size() && !abort && n < 20000) begin
      bus.valid = (($urandom % 4) != 0);
      bus.data  = words[sent_idx];
      @(negedge clk);
      hs = bus.valid && bus.ready;
      @(posedge clk); #1;
      if (hs) sent_idx++;
      n++;
    end
    bus.valid = 1'b0;
    sender_busy = 0;
  endtask

  task automatic start_xfer(input int len, input bit seq, input int errb);
    beat_t b;
    int k;
    words.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++)
      words.push_back(seq ? 8'(i + 1) : 8'($urandom));
    exp_total = (len + RATIO - 1) / RATIO;
    for (int i = 0; i < exp_total; i++) begin
      b.d = '0;
      b.s = '0;
      for (int l = 0; l < RATIO; l++) begin
        k = i * RATIO + l;
        if (k < len) begin
          b.d[8*l +: 8] = words[k];
          b.s[l] = 1'b1;
        end
      end
      b.l = ((i % BB) == BB - 1) || (i == exp_total - 1);
      exp_q.push_back(b);
    end
    exp_bursts = (exp_total + BB - 1) / BB;
    exp_err    = (errb >= 0) && (errb < exp_bursts);
    err_burst  = errb;
    wlast_cnt  = 0;
    b_sent     = 0;
    beat_cnt   = 0;
    done_cnt   = 0;
    abort      = 0;
    @(posedge clk); #1;
    chk("cfg_ready_idle", 64'(bus.cfg_ready), 64'(1));
    bus.cfg_length = len;
    bus.cfg_valid  = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    chk("error_cleared", 64'(bus.error), 64'(0));
    sender_busy = 1;
    fork
      sender();
    join_none
  endtask

  task automatic wait_sender();
    int n = 0;
    while (sender_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic finish_xfer();
    int n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_cnt != 0), 64'(1));
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'(1));
    chk("beats_seen", 64'(beat_cnt), 64'(exp_total));
    chk("b_count", 64'(b_sent), 64'(exp_bursts));
    chk("error_flag", 64'(bus.error), 64'(exp_err));
    chk("cfg_ready_after", 64'(bus.cfg_ready), 64'(1));
    wait_sender();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'(1));
    chk({tag, "_ready"},     64'(bus.ready), 64'(0));
    chk({tag, "_wvalid"},    64'(bus.axi_wvalid), 64'(0));
    chk({tag, "_wlast"},     64'(bus.axi_wlast), 64'(0));
    chk({tag, "_bready"},    64'(bus.axi_bready), 64'(0));
    chk({tag, "_done"},      64'(bus.done), 64'(0));
    chk({tag, "_error"},     64'(bus.error), 64'(0));
    chk({tag, "_wdata"},     64'(bus.axi_wdata), 64'(0));
    chk({tag, "_wstrb"},     64'(bus.axi_wstrb), 64'(0));
  endtask

  initial begin
    int n;
    bus.cfg_length = '0;
    bus.cfg_valid  = 1'b0;
    bus.data       = '0;
    bus.valid      = 1'b0;
    bus.axi_wready = 1'b0;
    bus.axi_bresp  = 2'b00;
    bus.axi_bvalid = 1'b0;
    fork
      monitor();
      bresp_proc();
      wready_proc();
    join_none

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // 16 full beats, one burst
    start_xfer(64, 1, -1);
    finish_xfer();
    // partial final word: 0x04030201 then 0x00000605 strobe 3
    start_xfer(6, 1, -1);
    finish_xfer();
    // 40 beats: bursts of 16/16/8
    start_xfer(160, 0, -1);
    finish_xfer();

    // W stalled: FIFO (4) plus head register fill, then stream stalls
    hold = 1;
    repeat (2) @(posedge clk);
    #1;
    start_xfer(40, 0, -1);
    repeat (50) @(posedge clk);
    #1;
    chk("accepted_under_stall", 64'(sent_idx), 64'(20));
    chk("ready_stalled", 64'(bus.ready), 64'(0));
    chk("wvalid_stalled", 64'(bus.axi_wvalid), 64'(1));
    hold = 0;
    finish_xfer();

    // second burst returns SLVERR
    start_xfer(128, 0, 1);
    finish_xfer();
    // zero length clears error, pulses done, no W traffic
    start_xfer(0, 0, -1);
    finish_xfer();

    // asynchronous reset in the middle of a burst
    start_xfer(64, 0, -1);
    n = 0;
    while (beat_cnt < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("beats_before_reset", 64'(beat_cnt >= 3), 64'(1));
    @(posedge clk); #1;
    rst   = 1'b0;
    abort = 1;
    #1;
    chk("rst_wvalid", 64'(bus.axi_wvalid), 64'(0));
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'(1));
    chk("rst_ready", 64'(bus.ready), 64'(0));
    chk("rst_bready", 64'(bus.axi_bready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    wait_sender();
    start_xfer(4, 0, -1);
    finish_xfer();

    // random lengths
    for (int i = 0; i < 4; i++) begin
      start_xfer($urandom_range(1, 200), 0,
                 (i == 2) ? 0 : -1);
      finish_xfer();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
